// File: rtl/instr_encoder.sv
// Field-level instruction encoder: assembles MIPS words from kind/field requests and writes them sequentially into imem.
// Optional macro ENCODER_BRANCH_ABS_EN: BEQ/BNE in_imm is an absolute word address converted to a PC-relative offset.
module instr_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W:0]     count_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic                last_q;
    logic                done_q;
    logic                accept;
    logic                final_acc;
    logic [15:0]         branch_imm;
    logic [31:0]         enc_d;

    function automatic logic [31:0] encode(
        input logic [2:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [15:0] bimm,
        input logic [25:0] target
    );
        logic [31:0] w;
        case (kind)
            3'd0:    w = {6'b000000, rs, rt, rd, 5'b00000, funct};
            3'd1:    w = {6'b000010, target};
            3'd2:    w = {6'b000100, rs, rt, bimm};
            3'd3:    w = {6'b000101, rs, rt, bimm};
            3'd4:    w = {6'b001000, rs, rt, imm};
            3'd5:    w = {6'b001100, rs, rt, imm};
            3'd6:    w = {6'b100011, rs, rt, imm};
            default: w = {6'b101011, rs, rt, imm};
        endcase
        return w;
    endfunction

`ifdef ENCODER_BRANCH_ABS_EN
    // Offset is relative to the slot after the branch (MIPS PC+4 semantics, in words).
    assign branch_imm = in_imm - (16'(ptr_q) + 16'd1);
`else
    assign branch_imm = in_imm;
`endif

    assign enc_d     = encode(in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, branch_imm, in_target);
    assign accept    = in_valid && in_ready && !start;
    assign final_acc = in_last || ((count_q + 1'b1) == DEPTH_C);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                LOAD:    if (accept && final_acc) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        in_ready = (state_q == LOAD) && (count_q < DEPTH_C);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            we_q <= accept;
            if (accept) begin
                addr_q  <= ptr_q;
                wdata_q <= enc_d;
                ptr_q   <= ptr_q + 1'b1;
                count_q <= count_q + 1'b1;
                last_q  <= final_acc;
            end
            if (start) begin
                ptr_q   <= '0;
                count_q <= '0;
                last_q  <= 1'b0;
                done_q  <= 1'b0;
            end else if (we_q && last_q) begin
                done_q <= 1'b1;
            end
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign done       = done_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: default-depth instance plus a DEPTH=4 instance sharing the same inputs.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, in_last;
    logic [2:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic        in_ready, imem_we, done;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0]  count;

    logic        d4_ready, d4_we, d4_done;
    logic [7:0]  d4_addr;
    logic [31:0] d4_wdata;
    logic [8:0]  d4_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8), .DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
        .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .done(done)
    );

    instr_encoder #(.ADDR_W(8), .DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(d4_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
        .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(d4_we), .imem_addr(d4_addr), .imem_wdata(d4_wdata),
        .count(d4_count), .done(d4_done)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_session();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Present one request for one cycle, then check the write pulse it produces.
    task automatic xfer(input string tag, input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                        input logic [25:0] target, input logic last,
                        input logic [7:0] exp_addr, input logic [31:0] exp_word);
        in_valid = 1'b1; in_kind = kind; in_rs = rs; in_rt = rt; in_rd = rd;
        in_funct = funct; in_imm = imm; in_target = target; in_last = last;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        chk({tag, "_we"},   imem_we,    1'b1);
        chk({tag, "_addr"}, imem_addr,  exp_addr);
        chk({tag, "_data"}, imem_wdata, exp_word);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_funct = '0; in_imm = '0; in_target = '0;
        step(); step();
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_we",    imem_we, 1'b0);
        chk("rst_addr",  imem_addr, 8'h00);
        chk("rst_data",  imem_wdata, 32'h0);
        chk("rst_count", count, 9'd0);
        chk("rst_done",  done, 1'b0);
        rst_n = 1'b1;
        step();
        chk("idle_ready", in_ready, 1'b0);

        // R-type with junk in unused fields
        begin_session();
        chk("load_ready", in_ready, 1'b1);
        xfer("r_add", 3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'hFFFF, 26'h3FFFFFF, 1'b0, 8'd0, 32'h00221820);
        chk("r_count", count, 9'd1);
        step();
        chk("r_we_pulse", imem_we, 1'b0);

        // Back-to-back I-type writes
        begin_session();
        xfer("addi", 3'd4, 5'd0, 5'd8, 5'd31, 6'h3F, 16'd5, 26'h1555555, 1'b0, 8'd0, 32'h20080005);
        xfer("lw",   3'd6, 5'd8, 5'd9, 5'd0,  6'h00, 16'd4, 26'h0,       1'b0, 8'd1, 32'h8D090004);
        chk("b2b_count", count, 9'd2);
        step();
        chk("b2b_we_end", imem_we, 1'b0);

        // Jump with in_last ends the session
        begin_session();
        xfer("j", 3'd1, 5'd7, 5'd7, 5'd7, 6'h11, 16'h1234, 26'h10, 1'b1, 8'd0, 32'h08000010);
        chk("j_ready", in_ready, 1'b0);
        chk("j_done_early", done, 1'b0);
        step();
        chk("j_done", done, 1'b1);
        chk("j_ready2", in_ready, 1'b0);
        chk("j_we_off", imem_we, 1'b0);
        step();
        chk("j_done_hold", done, 1'b1);
        begin_session();
        chk("restart_count", count, 9'd0);
        chk("restart_done",  done, 1'b0);
        chk("restart_ready", in_ready, 1'b1);

        // Branches and other I-types at increasing addresses
`ifdef ENCODER_BRANCH_ABS_EN
        xfer("beq0", 3'd2, 5'd1, 5'd2, 5'd0, 6'h0, 16'd3, 26'h0, 1'b0, 8'd0, 32'h10220002);
        xfer("andi", 3'd5, 5'd1, 5'd2, 5'd0, 6'h0, 16'hF0F0, 26'h0, 1'b0, 8'd1, 32'h3022F0F0);
        xfer("beq2", 3'd2, 5'd1, 5'd2, 5'd0, 6'h0, 16'd6, 26'h0, 1'b0, 8'd2, 32'h10220003);
        xfer("bne3", 3'd3, 5'd3, 5'd4, 5'd0, 6'h0, 16'h1234, 26'h0, 1'b0, 8'd3, 32'h14641230);
        xfer("sw",   3'd7, 5'd29, 5'd31, 5'd0, 6'h0, 16'd8, 26'h0, 1'b0, 8'd4, 32'hAFBF0008);
        xfer("beq5", 3'd2, 5'd1, 5'd2, 5'd0, 6'h0, 16'd2, 26'h0, 1'b0, 8'd5, 32'h1022FFFC);
`else
        xfer("beq0", 3'd2, 5'd1, 5'd2, 5'd0, 6'h0, 16'd3, 26'h0, 1'b0, 8'd0, 32'h10220003);
        xfer("andi", 3'd5, 5'd1, 5'd2, 5'd0, 6'h0, 16'hF0F0, 26'h0, 1'b0, 8'd1, 32'h3022F0F0);
        xfer("beq2", 3'd2, 5'd1, 5'd2, 5'd0, 6'h0, 16'd6, 26'h0, 1'b0, 8'd2, 32'h10220006);
        xfer("bne3", 3'd3, 5'd3, 5'd4, 5'd0, 6'h0, 16'h1234, 26'h0, 1'b0, 8'd3, 32'h14641234);
        xfer("sw",   3'd7, 5'd29, 5'd31, 5'd0, 6'h0, 16'd8, 26'h0, 1'b0, 8'd4, 32'hAFBF0008);
        xfer("beq5", 3'd2, 5'd1, 5'd2, 5'd0, 6'h0, 16'd2, 26'h0, 1'b0, 8'd5, 32'h10220002);
`endif
        chk("br_count", count, 9'd6);
        step();
        chk("br_we_end", imem_we, 1'b0);

        // start coinciding with a handshake drops the request
        in_valid = 1'b1; in_kind = 3'd4; in_last = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0; in_valid = 1'b0;
        chk("startwin_we",    imem_we, 1'b0);
        chk("startwin_count", count, 9'd0);

        // DEPTH=4 instance fills up with valid held high
        begin_session();
        in_valid = 1'b1; in_kind = 3'd4; in_rs = 5'd0; in_rt = 5'd8; in_imm = 16'd1; in_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("d4_we",   d4_we, 1'b1);
            chk("d4_addr", d4_addr, 8'(i));
        end
        chk("d4_data",  d4_wdata, 32'h20080001);
        chk("d4_full_ready", d4_ready, 1'b0);
        chk("d4_count", d4_count, 9'd4);
        step();
        chk("d4_done",   d4_done, 1'b1);
        chk("d4_no_we",  d4_we, 1'b0);
        chk("d4_ready_held", d4_ready, 1'b0);
        step();
        chk("d4_no_we2", d4_we, 1'b0);
        in_valid = 1'b0;

        // Reset sampled with a handshake: no write pulse, everything back to reset values
        begin_session();
        in_valid = 1'b1; in_kind = 3'd0; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_funct = 6'h20;
        rst_n = 1'b0;
        step();
        in_valid = 1'b0;
        chk("mrst_we",    imem_we, 1'b0);
        chk("mrst_count", count, 9'd0);
        chk("mrst_ready", in_ready, 1'b0);
        chk("mrst_addr",  imem_addr, 8'h00);
        chk("mrst_data",  imem_wdata, 32'h0);
        rst_n = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("mrst_nostart_we", imem_we, 1'b0);
        begin_session();
        chk("resume_ready", in_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
